// File: rtl/tick_burst_scheduler.sv
// Round-robin shared tick divider: one requester at a time owns the divider
// and receives a burst of N ticks spaced max(P,1) cycles apart.
module tick_burst_scheduler #(
  parameter int NUM_REQ  = 4,
  parameter int PERIOD_W = 8,
  parameter int COUNT_W  = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_i,
  input  logic [NUM_REQ*PERIOD_W-1:0]  period_in_i,
  input  logic [NUM_REQ*COUNT_W-1:0]   count_in_i,
  output logic [NUM_REQ-1:0]           grant_o,
  output logic [NUM_REQ-1:0]           done_o,
  output logic                         busy_o,
  output logic                         tick_out_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e              state_q;
  logic [NUM_REQ-1:0]  grant_q;
  logic [IDX_W-1:0]    owner_q;
  logic [IDX_W-1:0]    ptr_q;
  logic [PERIOD_W-1:0] pe_q;
  logic [PERIOD_W-1:0] div_q;
  logic [COUNT_W-1:0]  remaining_q;

  logic [IDX_W-1:0]    sel;
  logic                found;
  int                  idx;
  logic [PERIOD_W-1:0] selPeriod;
  logic [COUNT_W-1:0]  selCount;
  logic [IDX_W-1:0]    ptrNext;
  logic                tick;

  // First pending request at or above the pointer, wrapping to requester 0.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_i[idx]) begin
        sel   = IDX_W'(idx);
        found = 1'b1;
      end
    end
  end

  assign selPeriod = period_in_i[sel*PERIOD_W +: PERIOD_W];
  assign selCount  = count_in_i[sel*COUNT_W +: COUNT_W];
  assign ptrNext   = (sel == IDX_W'(NUM_REQ-1)) ? '0 : sel + 1'b1;
  assign tick      = (state_q == RUN) && (div_q == pe_q - PERIOD_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      owner_q     <= '0;
      ptr_q       <= '0;
      pe_q        <= '0;
      div_q       <= '0;
      remaining_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            grant_q <= NUM_REQ'(1) << sel;
            owner_q <= sel;
            ptr_q   <= ptrNext;
            pe_q    <= (selPeriod == '0) ? PERIOD_W'(1) : selPeriod;
            div_q   <= '0;
            if (selCount == '0) begin
              state_q     <= DONE;
              remaining_q <= '0;
            end else begin
              state_q     <= RUN;
              remaining_q <= selCount;
            end
          end
        end
        RUN: begin
          // A dropped request abandons the burst silently; no done pulse.
          if (!req_i[owner_q]) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            div_q       <= '0;
            remaining_q <= '0;
          end else if (tick) begin
            div_q       <= '0;
            remaining_q <= remaining_q - COUNT_W'(1);
            if (remaining_q == COUNT_W'(1)) state_q <= DONE;
          end else begin
            div_q <= div_q + PERIOD_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  assign grant_o    = grant_q;
  assign done_o     = (state_q == DONE) ? grant_q : '0;
  assign busy_o     = (state_q != IDLE);
  assign tick_out_o = tick;

endmodule

// File: tb/tb_tick_burst_scheduler.sv
// Scoreboard bench: stimulus queues expected output events (grant changes, ticks,
// done pulses) tagged with their cycle position inside the current ownership.
module tb_tick_burst_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] periodIn;
  logic [31:0] countIn;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        busy;
  logic        tickOut;

  typedef struct packed {
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        tick;
    logic        busy;
    logic [15:0] pos;
  } ev_t;

  ev_t  expQ[$];
  int   checkCount = 0;
  int   passCount  = 0;
  int   evNum      = 0;
  int   pos        = 0;
  logic [3:0] prevGrant = 4'b0000;

  tick_burst_scheduler #(.NUM_REQ(4), .PERIOD_W(8), .COUNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_i      (req),
    .period_in_i(periodIn),
    .count_in_i (countIn),
    .grant_o    (grant),
    .done_o     (done),
    .busy_o     (busy),
    .tick_out_o (tickOut)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  task automatic pushEv(input logic [3:0] g, input logic [3:0] d, input logic t,
                        input logic b, input int p);
    ev_t e;
    e.grant = g; e.done = d; e.tick = t; e.busy = b; e.pos = 16'(p);
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input int idx, input int p, input int n);
    periodIn[idx*8 +: 8] = 8'(p);
    countIn[idx*8 +: 8]  = 8'(n);
  endtask

  task automatic stepCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic waitDone(input int budget);
    int n;
    n = 0;
    do begin
      stepCycles(1);
      n++;
    end while (done == 4'b0000 && n < budget);
    if (done == 4'b0000) begin
      checkCount++;
      $display("[TB] FAIL waitDone timeout after %0d cycles, done=%b required nonzero", n, done);
    end
  endtask

  task automatic waitGrant(input int budget);
    int n;
    n = 0;
    do begin
      stepCycles(1);
      n++;
    end while (grant == 4'b0000 && n < budget);
    if (grant == 4'b0000) begin
      checkCount++;
      $display("[TB] FAIL waitGrant timeout after %0d cycles, grant=%b required nonzero", n, grant);
    end
  endtask

  // Monitor: pos is 1 in the first cycle a new owner is granted and counts up from there.
  always @(negedge clk) begin
    ev_t act;
    ev_t exp;
    if (grant != 4'b0000 && grant != prevGrant) pos = 1;
    else pos = pos + 1;
    if (grant != prevGrant || tickOut || done != 4'b0000) begin
      act.grant = grant; act.done = done; act.tick = tickOut; act.busy = busy;
      act.pos = 16'(pos);
      evNum++;
      if (expQ.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL unexpectedEvent#%0d actual=%h required=none", evNum, act);
      end else begin
        exp = expQ.pop_front();
        checkOutput($sformatf("event#%0d", evNum), {6'b0, act}, {6'b0, exp});
      end
    end
    prevGrant = grant;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1; req = 4'b0000; periodIn = '0; countIn = '0;
    stepCycles(3);
    reset = 1'b0;
    checkOutput("resetGrant", {28'b0, grant}, 32'd0);
    checkOutput("resetDone",  {28'b0, done},  32'd0);
    checkOutput("resetBusy",  {31'b0, busy},  32'd0);
    checkOutput("resetTick",  {31'b0, tickOut}, 32'd0);

    // Single burst P=5 N=3 on requester 0.
    applyStimulus(0, 5, 3);
    pushEv(4'b0001, 4'b0000, 1'b0, 1'b1, 1);
    pushEv(4'b0001, 4'b0000, 1'b1, 1'b1, 5);
    pushEv(4'b0001, 4'b0000, 1'b1, 1'b1, 10);
    pushEv(4'b0001, 4'b0000, 1'b1, 1'b1, 15);
    pushEv(4'b0001, 4'b0001, 1'b0, 1'b1, 16);
    pushEv(4'b0000, 4'b0000, 1'b0, 1'b0, 17);
    req = 4'b0001;
    waitDone(40);
    req = 4'b0000;
    stepCycles(4);

    // Round robin from a fresh pointer, all requests held.
    reset = 1'b1;
    stepCycles(2);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(i, 1, 2);
    for (int b = 0; b < 5; b++) begin
      logic [3:0] g;
      g = 4'b0001 << (b % 4);
      pushEv(g, 4'b0000, 1'b1, 1'b1, 1);
      pushEv(g, 4'b0000, 1'b1, 1'b1, 2);
      pushEv(g, g,       1'b0, 1'b1, 3);
      pushEv(4'b0000, 4'b0000, 1'b0, 1'b0, 4);
    end
    req = 4'b1111;
    for (int b = 0; b < 5; b++) waitDone(20);
    req = 4'b0000;
    stepCycles(4);

    // Zero count on requester 1.
    applyStimulus(1, 7, 0);
    pushEv(4'b0010, 4'b0010, 1'b0, 1'b1, 1);
    pushEv(4'b0000, 4'b0000, 1'b0, 1'b0, 2);
    req = 4'b0010;
    waitDone(20);
    req = 4'b0000;
    stepCycles(3);

    // P=0 on requester 2, P=1 on requester 3, N=4 each.
    applyStimulus(2, 0, 4);
    applyStimulus(3, 1, 4);
    for (int r = 2; r < 4; r++) begin
      logic [3:0] g;
      g = 4'b0001 << r;
      for (int k = 1; k <= 4; k++) pushEv(g, 4'b0000, 1'b1, 1'b1, k);
      pushEv(g, g, 1'b0, 1'b1, 5);
      pushEv(4'b0000, 4'b0000, 1'b0, 1'b0, 6);
      req = g;
      waitDone(20);
      req = 4'b0000;
      stepCycles(3);
    end

    // Maximum period, single tick.
    applyStimulus(0, 255, 1);
    pushEv(4'b0001, 4'b0000, 1'b0, 1'b1, 1);
    pushEv(4'b0001, 4'b0000, 1'b1, 1'b1, 255);
    pushEv(4'b0001, 4'b0001, 1'b0, 1'b1, 256);
    pushEv(4'b0000, 4'b0000, 1'b0, 1'b0, 257);
    req = 4'b0001;
    waitDone(400);
    req = 4'b0000;
    stepCycles(3);

    // Abort requester 2 after 7 owned cycles; pointer must then favour requester 3.
    applyStimulus(2, 4, 10);
    pushEv(4'b0100, 4'b0000, 1'b0, 1'b1, 1);
    pushEv(4'b0100, 4'b0000, 1'b1, 1'b1, 4);
    pushEv(4'b0000, 4'b0000, 1'b0, 1'b0, 8);
    req = 4'b0100;
    waitGrant(10);
    stepCycles(6);
    req = 4'b0000;
    stepCycles(3);
    applyStimulus(3, 1, 1);
    applyStimulus(2, 1, 1);
    pushEv(4'b1000, 4'b0000, 1'b1, 1'b1, 1);
    pushEv(4'b1000, 4'b1000, 1'b0, 1'b1, 2);
    pushEv(4'b0000, 4'b0000, 1'b0, 1'b0, 3);
    req = 4'b1100;
    waitDone(20);
    req = 4'b0000;
    stepCycles(3);

    // Reset in the middle of a P=3 N=5 burst, then requester 1 wins from pointer 0.
    applyStimulus(0, 3, 5);
    applyStimulus(1, 2, 1);
    pushEv(4'b0001, 4'b0000, 1'b0, 1'b1, 1);
    pushEv(4'b0001, 4'b0000, 1'b1, 1'b1, 3);
    pushEv(4'b0000, 4'b0000, 1'b0, 1'b0, 6);
    req = 4'b0001;
    waitGrant(10);
    stepCycles(4);
    reset = 1'b1;
    stepCycles(1);
    checkOutput("midResetGrant", {28'b0, grant}, 32'd0);
    checkOutput("midResetDone",  {28'b0, done},  32'd0);
    checkOutput("midResetBusy",  {31'b0, busy},  32'd0);
    checkOutput("midResetTick",  {31'b0, tickOut}, 32'd0);
    pushEv(4'b0010, 4'b0000, 1'b0, 1'b1, 1);
    pushEv(4'b0010, 4'b0000, 1'b1, 1'b1, 2);
    pushEv(4'b0010, 4'b0010, 1'b0, 1'b1, 3);
    pushEv(4'b0000, 4'b0000, 1'b0, 1'b0, 4);
    reset = 1'b0;
    req = 4'b1010;
    waitDone(20);
    req = 4'b0000;
    stepCycles(3);

    // Requester 3 arrives while requester 1 runs; served right after one idle cycle.
    applyStimulus(1, 2, 2);
    applyStimulus(3, 1, 1);
    pushEv(4'b0010, 4'b0000, 1'b0, 1'b1, 1);
    pushEv(4'b0010, 4'b0000, 1'b1, 1'b1, 2);
    pushEv(4'b0010, 4'b0000, 1'b1, 1'b1, 4);
    pushEv(4'b0010, 4'b0010, 1'b0, 1'b1, 5);
    pushEv(4'b0000, 4'b0000, 1'b0, 1'b0, 6);
    pushEv(4'b1000, 4'b0000, 1'b1, 1'b1, 1);
    pushEv(4'b1000, 4'b1000, 1'b0, 1'b1, 2);
    pushEv(4'b0000, 4'b0000, 1'b0, 1'b0, 3);
    req = 4'b0010;
    waitGrant(10);
    stepCycles(1);
    req = 4'b1010;
    waitDone(20);
    req = 4'b1000;
    waitDone(20);
    req = 4'b0000;
    stepCycles(5);

    checkOutput("expectedQueueEmpty", 32'(expQ.size()), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
